// File: rtl/md5_search_dispatcher.sv
// Brute-force MD5 candidate generator: enumerates LEN-char strings over a
// charset RAM, deals them round-robin to NUM_CORES MD5 cores and watches the
// returned digests for target_hash.

// Per-core digest check: a digest only counts while that core has work out.
module md5_core_cmp (
    input  logic [127:0] digest,
    input  logic [127:0] target,
    input  logic         digest_valid,
    input  logic         inflight,
    output logic         done,
    output logic         match
);
    assign done  = digest_valid & inflight;
    assign match = done & (digest == target);
endmodule

module md5_search_dispatcher #(
    parameter int NUM_CORES    = 2,
    parameter int CORE_IDX_W   = 1,
    parameter int LEN          = 8,
    parameter int DIGIT_BITS   = 6,
    parameter int CHARSET_SIZE = 64,
    parameter int COUNT_W      = 48
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [127:0]              target_hash,
    output logic [DIGIT_BITS-1:0]     cs_addr,
    input  logic [7:0]                cs_data,
    output logic [NUM_CORES*128-1:0]  core_msg,
    output logic [7:0]                core_msg_width,
    output logic [NUM_CORES-1:0]      core_msg_valid,
    input  logic [NUM_CORES-1:0]      core_ready,
    input  logic [NUM_CORES*128-1:0]  core_digest,
    input  logic [NUM_CORES-1:0]      core_digest_valid,
    output logic                      busy,
    output logic                      found,
    output logic                      exhausted,
    output logic [8*LEN-1:0]          found_msg,
    output logic [CORE_IDX_W-1:0]     found_core,
    output logic [COUNT_W-1:0]        tried
);
    localparam int FW = $clog2(LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DISPATCH, S_DRAIN, S_FOUND, S_EXHAUSTED
    } state_t;

    state_t                         state_q, state_d;
    logic [FW-1:0]                  fcnt_q, fcnt_d;
    logic [LEN-1:0][DIGIT_BITS-1:0] dig_q, dig_d, dig_inc;
    logic                           carry;
    logic [LEN-1:0][7:0]            cand_q, cand_d;   // element LEN-1 holds char 0
    logic [NUM_CORES-1:0][127:0]    msg_q, msg_d;
    logic [NUM_CORES-1:0]           vld_q, vld_d, infl_q, infl_d;
    logic [CORE_IDX_W-1:0]          rr_q, rr_d;
    logic [COUNT_W-1:0]             tried_q, tried_d;
    logic                           found_q, found_d, exh_q, exh_d;
    logic [8*LEN-1:0]               fmsg_q, fmsg_d;
    logic [CORE_IDX_W-1:0]          fcore_q, fcore_d;
    logic [NUM_CORES-1:0]           done_vec, match_vec, grant;
    logic                           grant_ok, hit;
    logic [CORE_IDX_W-1:0]          grant_next, hit_idx;
    logic [8*LEN-1:0]               hit_msg;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_cmp
        md5_core_cmp u_cmp (
            .digest       (core_digest[128*g +: 128]),
            .target       (target_hash),
            .digest_valid (core_digest_valid[g]),
            .inflight     (infl_q[g]),
            .done         (done_vec[g]),
            .match        (match_vec[g])
        );
    end

    // Mixed-radix increment of the digit vector; carry out means keyspace done.
    always_comb begin
        dig_inc = dig_q;
        carry   = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            if (carry) begin
                if (dig_q[k] == DIGIT_BITS'(CHARSET_SIZE - 1)) begin
                    dig_inc[k] = '0;
                end else begin
                    dig_inc[k] = dig_q[k] + DIGIT_BITS'(1);
                    carry      = 1'b0;
                end
            end
        end
    end

    // Round-robin pick of the first free, ready core starting at rr.
    always_comb begin
        grant      = '0;
        grant_ok   = 1'b0;
        grant_next = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!grant_ok && core_ready[(int'(rr_q) + k) % NUM_CORES]
                          && !infl_q[(int'(rr_q) + k) % NUM_CORES]) begin
                grant_ok = 1'b1;
                grant[(int'(rr_q) + k) % NUM_CORES] = 1'b1;
                grant_next = CORE_IDX_W'((int'(rr_q) + k + 1) % NUM_CORES);
            end
        end
    end

    // Lowest-index matching core wins; its last message is the cleartext,
    // since core_msg is frozen while the core is inflight.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_msg = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit     = 1'b1;
                hit_idx = CORE_IDX_W'(i);
                hit_msg = msg_q[i][8*LEN-1:0];
            end
        end
    end

    // Charset address for the digit being fetched this cycle.
    always_comb begin
        cs_addr = '0;
        if (state_q == S_FETCH) begin
            for (int k = 0; k < LEN; k++) begin
                if (fcnt_q == FW'(k)) cs_addr = dig_q[k];
            end
        end
    end

    // Next-state and datapath updates; abort overrides everything.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        dig_d   = dig_q;
        cand_d  = cand_q;
        msg_d   = msg_q;
        vld_d   = '0;
        infl_d  = infl_q;
        rr_d    = rr_q;
        tried_d = tried_q;
        found_d = found_q;
        exh_d   = exh_q;
        fmsg_d  = fmsg_q;
        fcore_d = fcore_q;
        if (abort) begin
            state_d = S_IDLE;
            infl_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_FOUND, S_EXHAUSTED: begin
                    if (start) begin
                        state_d = S_FETCH;
                        fcnt_d  = '0;
                        dig_d   = '0;
                        tried_d = '0;
                        found_d = 1'b0;
                        exh_d   = 1'b0;
                        infl_d  = '0;
                    end
                end
                default: begin
                    infl_d = infl_q & ~done_vec;
                    if (hit) begin
                        state_d = S_FOUND;
                        found_d = 1'b1;
                        fmsg_d  = hit_msg;
                        fcore_d = hit_idx;
                    end else if (state_q == S_FETCH) begin
                        for (int k = 0; k < LEN; k++) begin
                            if (fcnt_q == FW'(LEN - k)) cand_d[k] = cs_data;
                        end
                        if (fcnt_q == FW'(LEN)) begin
                            state_d = S_DISPATCH;
                            fcnt_d  = '0;
                        end else begin
                            fcnt_d = fcnt_q + FW'(1);
                        end
                    end else if (state_q == S_DISPATCH) begin
                        if (grant_ok) begin
                            for (int i = 0; i < NUM_CORES; i++) begin
                                if (grant[i]) msg_d[i] = 128'(cand_q);
                            end
                            vld_d   = grant;
                            infl_d  = infl_d | grant;
                            rr_d    = grant_next;
                            tried_d = tried_q + COUNT_W'(1);
                            dig_d   = dig_inc;
                            fcnt_d  = '0;
                            state_d = carry ? S_DRAIN : S_FETCH;
                        end
                    end else if (infl_q == '0) begin
                        state_d = S_EXHAUSTED;
                        exh_d   = 1'b1;
                    end
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            dig_q   <= '0;
            cand_q  <= '0;
            msg_q   <= '0;
            vld_q   <= '0;
            infl_q  <= '0;
            rr_q    <= '0;
            tried_q <= '0;
            found_q <= 1'b0;
            exh_q   <= 1'b0;
            fmsg_q  <= '0;
            fcore_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            dig_q   <= dig_d;
            cand_q  <= cand_d;
            msg_q   <= msg_d;
            vld_q   <= vld_d;
            infl_q  <= infl_d;
            rr_q    <= rr_d;
            tried_q <= tried_d;
            found_q <= found_d;
            exh_q   <= exh_d;
            fmsg_q  <= fmsg_d;
            fcore_q <= fcore_d;
        end
    end

    assign core_msg       = msg_q;
    assign core_msg_valid = vld_q;
    assign core_msg_width = 8'(8 * LEN);
    assign busy           = (state_q == S_FETCH) || (state_q == S_DISPATCH) || (state_q == S_DRAIN);
    assign found          = found_q;
    assign exhausted      = exh_q;
    assign found_msg      = fmsg_q;
    assign found_core     = fcore_q;
    assign tried          = tried_q;
endmodule

// File: tb/tb_md5_search_dispatcher.sv
// Bench for md5_search_dispatcher: fake cores echo the message as digest,
// a scoreboard predicts dispatch order/content from the keyspace enumeration.
module tb_md5_search_dispatcher;
    localparam int NC = 4, IW = 2, LEN = 2, DB = 2, CS = 3, CW = 16, NCAND = 9;

    logic               clk = 0, reset_n = 0, start = 0, abort = 0;
    logic [127:0]       target_hash = '1;
    logic [DB-1:0]      cs_addr;
    logic [7:0]         cs_data;
    logic [NC*128-1:0]  core_msg;
    logic [7:0]         core_msg_width;
    logic [NC-1:0]      core_msg_valid;
    logic [NC-1:0]      core_ready = '0;
    logic [NC*128-1:0]  core_digest = '0;
    logic [NC-1:0]      core_digest_valid = '0;
    logic               busy, found, exhausted;
    logic [8*LEN-1:0]   found_msg;
    logic [IW-1:0]      found_core;
    logic [CW-1:0]      tried;

    int total = 0, bad = 0;
    logic [7:0] ram [0:3];

    // fake core knobs and state
    int           lat [NC];
    bit           hold = 0, rnd_ready = 0, force_dg = 0;
    logic [NC-1:0] rel_mask = '0, ready_mask = '1;
    bit           fbusy [NC];
    int           fcnt [NC];
    logic [127:0] fmsg [NC];

    // scoreboard
    logic [127:0] exp_q [$];
    int           exp_core [NCAND];
    int           obs_core [$];
    int           pos = 0, rr_m = 0;
    logic [NC-1:0] ready_prev = '0;

    md5_search_dispatcher #(
        .NUM_CORES(NC), .CORE_IDX_W(IW), .LEN(LEN), .DIGIT_BITS(DB),
        .CHARSET_SIZE(CS), .COUNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .target_hash(target_hash), .cs_addr(cs_addr), .cs_data(cs_data),
        .core_msg(core_msg), .core_msg_width(core_msg_width),
        .core_msg_valid(core_msg_valid), .core_ready(core_ready),
        .core_digest(core_digest), .core_digest_valid(core_digest_valid),
        .busy(busy), .found(found), .exhausted(exhausted),
        .found_msg(found_msg), .found_core(found_core), .tried(tried)
    );

    always #5 clk = ~clk;

    // sync-read charset RAM
    always @(posedge clk) cs_data <= ram[cs_addr];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // candidate n of the enumeration: digit k = (n / CS^k) % CS, char 0 in MSB byte
    function automatic logic [127:0] cand(input int n);
        logic [127:0] m;
        int v;
        m = '0;
        v = n;
        for (int k = 0; k < LEN; k++) begin
            m[8*(LEN-k)-1 -: 8] = ram[v % CS];
            v = v / CS;
        end
        return m;
    endfunction

    // fake cores: accept on strobe, answer digest=msg after lat cycles (or on release in hold mode)
    initial begin : fake
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                for (int i = 0; i < NC; i++) fbusy[i] = 0;
                core_digest_valid = '0;
                core_ready = '0;
                rel_mask = '0;
            end else begin
                for (int i = 0; i < NC; i++) begin
                    core_digest_valid[i] = 1'b0;
                    if (fbusy[i]) begin
                        if (hold ? rel_mask[i] : (fcnt[i] == 0)) begin
                            core_digest_valid[i] = 1'b1;
                            core_digest[128*i +: 128] = force_dg ? target_hash : fmsg[i];
                            fbusy[i] = 0;
                        end else if (!hold) begin
                            fcnt[i]--;
                        end
                    end
                    if (core_msg_valid[i]) begin
                        fbusy[i] = 1;
                        fmsg[i] = core_msg[128*i +: 128];
                        fcnt[i] = lat[i];
                    end
                    core_ready[i] = !fbusy[i] && !core_digest_valid[i] && ready_mask[i]
                                    && (!rnd_ready || $urandom_range(3) != 0);
                end
                rel_mask = '0;
            end
        end
    end

    // monitor: every strobe is checked for content and round-robin choice
    initial begin : mon
        int e;
        logic [127:0] x;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rr_m = 0;
                ready_prev = '0;
            end else begin
                if (|core_msg_valid) chk("one_strobe", $countones(core_msg_valid), 1);
                for (int i = 0; i < NC; i++) begin
                    if (core_msg_valid[i]) begin
                        e = -1;
                        for (int k = 0; k < NC; k++)
                            if (e < 0 && ready_prev[(rr_m + k) % NC]) e = (rr_m + k) % NC;
                        chk("rr_core", i, e);
                        rr_m = ((e >= 0 ? e : i) + 1) % NC;
                        if (exp_q.size() == 0) begin
                            chk("extra_dispatch", 1, 0);
                        end else begin
                            x = exp_q.pop_front();
                            chk("msg", core_msg[128*i +: 128], x);
                        end
                        if (pos < NCAND) exp_core[pos] = e;
                        pos++;
                        obs_core.push_back(i);
                    end
                end
                ready_prev = core_ready;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        tick();
    endtask

    task automatic do_start(input logic [127:0] tgt);
        target_hash = tgt;
        exp_q.delete();
        obs_core.delete();
        for (int n = 0; n < NCAND; n++) begin
            exp_q.push_back(cand(n));
            exp_core[n] = -1;
        end
        pos = 0;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(found || exhausted) && n < 3000) begin
            tick();
            n++;
        end
        chk("done_timeout", found | exhausted, 1);
    endtask

    task automatic wait_strobes(input int n);
        int c = 0;
        while (obs_core.size() < n && c < 500) begin
            tick();
            c++;
        end
        chk("strobe_timeout", obs_core.size() >= n, 1);
    endtask

    task automatic run_exhaust();
        wait_done();
        chk("exh_flag", exhausted, 1);
        chk("exh_found", found, 0);
        chk("exh_tried", tried, NCAND);
        chk("exh_busy", busy, 0);
        chk("exh_all_seen", exp_q.size(), 0);
    endtask

    task automatic run_found(input int m);
        logic [NC-1:0] v;
        logic [127:0] c;
        wait_done();
        c = cand(m);
        chk("fnd_flag", found, 1);
        chk("fnd_msg", found_msg, c[8*LEN-1:0]);
        chk("fnd_core", found_core, exp_core[m]);
        chk("fnd_tried", tried, pos);
        chk("fnd_tried_ge", pos > m, 1);
        chk("fnd_busy", busy, 0);
        v = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            v = v | core_msg_valid;
        end
        chk("fnd_quiet", v, 0);
    endtask

    initial begin : main
        logic [NC-1:0] v;
        int m;
        ram[0] = "a"; ram[1] = "b"; ram[2] = "c"; ram[3] = 8'h00;
        for (int i = 0; i < NC; i++) lat[i] = 3;

        // reset state
        tick();
        chk("rst_outs", {busy, found, exhausted, core_msg_valid, tried, found_core, cs_addr}, 0);
        chk("rst_msg", {core_msg, found_msg}, 0);
        chk("msg_width", core_msg_width, 8 * LEN);
        tick();
        reset_n = 1;
        tick();

        // 1: full enumeration over "abc", no match
        do_start('1);
        run_exhaust();

        // 2: target "bc"
        do_start(cand(7));
        run_found(7);
        chk("fnd_bc", found_msg, 16'h6263);

        // 3: all ready, latency 20 -> cores 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NC; i++) lat[i] = 20;
        do_start('1);
        wait_strobes(5);
        for (int i = 0; i < 5 && i < obs_core.size(); i++) chk("rr_order", obs_core[i], i % NC);
        run_exhaust();

        // 4: cores 1 and 3 match in the same cycle
        do_reset();
        hold = 1;
        do_start(128'h1234);
        wait_strobes(4);
        repeat (10) tick();
        force_dg = 1;
        rel_mask = 4'b1010;
        wait_done();
        chk("dual_core", found_core, 1);
        m = 1;
        chk("dual_msg", found_msg, cand(m) & 128'hffff);
        chk("dual_tried", tried, 4);
        force_dg = 0;
        hold = 0;
        do_reset();

        // 5: abort in DISPATCH, late matching digest ignored
        hold = 1;
        ready_mask = 4'b0111;
        do_start(128'h1234);
        wait_strobes(3);
        repeat (10) tick();
        chk("stall_busy", busy, 1);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", busy, 0);
        force_dg = 1;
        rel_mask = 4'b0100;
        v = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            v = v | core_msg_valid;
        end
        chk("abort_found", found, 0);
        chk("abort_idle", busy, 0);
        chk("abort_quiet", v, 0);
        force_dg = 0;
        hold = 0;
        ready_mask = '1;
        do_reset();

        // 6: reset during FETCH, then restart from "aa"
        for (int i = 0; i < NC; i++) lat[i] = 3;
        rnd_ready = 1;
        do_start('1);
        tick();
        chk("fetch_busy", busy, 1);
        #2 reset_n = 0;
        #1;
        chk("midrst_outs", {busy, found, exhausted, core_msg_valid, tried, found_core, cs_addr}, 0);
        chk("midrst_msg", {core_msg, found_msg}, 0);
        tick();
        reset_n = 1;
        tick();
        do_start('1);
        run_exhaust();
        if (obs_core.size() > 0) chk("restart_core0", obs_core[0], 0);

        // randomized rounds: distinct random charset, random latencies/readiness
        for (int r = 0; r < 8; r++) begin
            repeat (40) tick();
            for (int j = 0; j < CS; j++) begin
                logic [7:0] b;
                bit dup;
                do begin
                    b = 8'($urandom_range(255));
                    dup = 0;
                    for (int q = 0; q < j; q++) if (ram[q] == b) dup = 1;
                end while (dup);
                ram[j] = b;
            end
            for (int i = 0; i < NC; i++) lat[i] = $urandom_range(1, 12);
            if ($urandom_range(1) == 1) begin
                m = $urandom_range(0, NCAND - 1);
                do_start(cand(m));
                run_found(m);
            end else begin
                do_start('1);
                run_exhaust();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
